branch_resolve_ctrl: RTL
========================

// Module: branch_resolve_ctrl
// PURPOSE
//  Sequences branch resolution between dispatch, the branch execution unit and fetch.
//  Records each dispatched branch (tag, predicted direction, fall-through PC) in an age-ordered table.
//  Checks every branch-unit result against its prediction; frees the entry on a hit.
//  On a mispredict: redirects fetch, flushes the branch and all younger work, and stalls dispatch until recovery ends.
// PARAMETERS
//  TAG_W        5   instruction tag width; all-ones = TAG_INVALID
//  ADDR_W       32  PC width
//  MAX_BR       4   max in-flight branches (power of 2, >=2)
//  FLUSH_CYCLES 2   cycles flush is held after a mispredict (>=1)
// PORTS
//  clk              in   1                   clock; all state updates on posedge
//  rst              in   1                   synchronous, active-high reset
//  disp_valid       in   1                   dispatch offers a branch this cycle
//  disp_tag         in   TAG_W               ROB tag of the dispatched branch
//  disp_pred_taken  in   1                   predicted direction
//  disp_fallthru_pc in   ADDR_W              pc+4 of the branch
//  disp_ready       out  1                   table can accept a branch
//  res_tag          in   TAG_W               branch-unit result tag; TAG_INVALID = no result
//  res_taken        in   1                   resolved direction (cmp_res)
//  res_target_pc    in   ADDR_W              resolved taken target (next_pc)
//  redirect_valid   out  1                   one-cycle fetch redirect strobe
//  redirect_pc      out  ADDR_W              correct next PC
//  flush            out  1                   kill younger-than-flush_tag work
//  flush_tag        out  TAG_W               tag of the mispredicted branch
//  outstanding      out  $clog2(MAX_BR+1)    valid table entries
// BEHAVIOUR
//  Reset: table empty, head=tail=0, state RUN. Outputs: redirect_valid=0, redirect_pc=0, flush=0, flush_tag=TAG_INVALID, outstanding=0.
//  Rst mid-FLUSH aborts recovery and returns to RUN immediately.
//  Table: circular buffer MAX_BR deep. Entries are allocated in order at tail; each holds valid, tag, pred_taken, fallthru_pc.
//  disp_ready = (state==RUN) && (outstanding<MAX_BR). This is combinational and does not depend on res_*.
//  Dispatch: on disp_valid && disp_ready, write the entry at tail and advance tail at the edge.
//  Result: if state==RUN and res_tag!=TAG_INVALID, CAM-match res_tag against valid entries.
//   - No match: ignore (stale result after a flush). No state change.
//   - Match, res_taken==pred_taken: clear that entry's valid.
//   - Match, res_taken!=pred_taken: mispredict. At the next edge:
//     - redirect_pc = res_taken ? res_target_pc : fallthru_pc.
//     - redirect_valid=1 for exactly 1 cycle.
//     - flush=1 and flush_tag=res_tag; both held FLUSH_CYCLES cycles, starting the same cycle as redirect_valid.
//     - clear the matched entry and every younger entry (matched index .. tail-1). Tail moves to the matched index.
//     - state -> FLUSH.
//  Head retire: after each update, head skips over invalid entries until it reaches tail; one skip per cycle is sufficient.
//  Same-cycle dispatch and result:
//   - the result is evaluated against pre-edge entries only;
//   - an accepted dispatch in a mispredict cycle is younger, so it is discarded (not written);
//   - an accepted dispatch in a correct-resolution cycle is written normally.
//  FSM:
//   - RUN -> FLUSH on mispredict.
//   - FLUSH: count FLUSH_CYCLES; results ignored; disp_ready=0.
//   - FLUSH -> RUN when count expires. flush drops in the same cycle that disp_ready may rise.
//  outstanding = popcount(valid); registered, updated every edge.
//  Latency: result sampled at edge N -> redirect/flush visible after edge N.
//  Full: at MAX_BR entries disp_ready=0. A correct resolution frees a slot; disp_ready=1 the following cycle.
//  Wrap-around: head and tail are log2(MAX_BR) bits plus a wrap bit; full/empty are distinguished by the wrap bit.
// STRUCTURE
//  Shared package br_ctrl_pkg holds:
//   - br_entry_t struct {valid, tag, pred_taken, fallthru_pc};
//   - br_state_e enum {BR_RUN, BR_FLUSH};
//   - TAG_INVALID constant.
//  Sub-module br_age_queue: circular table with alloc, CAM lookup, clear-one and kill-younger-from-index ports.
//  Top holds the FSM, flush counter and redirect regs.
// TESTING
//  1. Reset, then dispatch tags 1,2,3 (pred NT). Expect outstanding=3, disp_ready=1. Results 1,2,3 with taken=0 -> outstanding=0, no redirect.
//  2. Dispatch tag 4 pred NT, fallthru 0x104. Result tag 4, taken=1, target 0x200:
//     -> redirect_valid 1 cycle, redirect_pc=0x200, flush 2 cycles with flush_tag=4; outstanding=0.
//  3. Dispatch tags 5,6,7; result 6 mispredicts (pred T, taken 0, fallthru 0x30):
//     -> redirect_pc=0x30; entries 6,7 killed; outstanding=1; a later result for 7 is ignored.
//  4. Fill 4 entries -> disp_ready=0. Correct result for the oldest -> disp_ready=1 next cycle.
//     Run 10 alloc/free rounds to exercise head/tail wrap.
//  5. Same cycle: dispatch tag 9 and a mispredict on tag 8 -> tag 9 not allocated.
//     Same cycle: dispatch tag 9 and a correct result on tag 8 -> tag 9 allocated.
//  6. Assert rst during FLUSH cycle 1 -> next cycle: flush=0, flush_tag=TAG_INVALID, outstanding=0, disp_ready=1.

Source files
------------

// File: rtl/br_ctrl_pkg.sv
// Shared types for the branch resolution controller.
//   br_entry_t  : one age-table entry (valid, tag, predicted direction, fall-through PC)
//   br_state_e  : controller state (normal run / mispredict recovery)
//   TAG_INVALID : all-ones tag meaning "no instruction / no result"
package br_ctrl_pkg;

    localparam int unsigned BR_TAG_W  = 5;
    localparam int unsigned BR_ADDR_W = 32;

    localparam logic [BR_TAG_W-1:0] TAG_INVALID = '1;

    typedef struct packed {
        logic                 valid;
        logic [BR_TAG_W-1:0]  tag;
        logic                 pred_taken;
        logic [BR_ADDR_W-1:0] fallthru_pc;
    } br_entry_t;

    typedef enum logic {
        BR_RUN   = 1'b0,
        BR_FLUSH = 1'b1
    } br_state_e;

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// Bundle of the dispatch, branch-unit result and fetch/flush signals.
//   master : drives dispatch and result inputs, observes ready/redirect/flush
//   slave  : the controller side
interface branch_resolve_ctrl_if #(
    parameter int unsigned TAG_W  = 5,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned MAX_BR = 4
) ();
    localparam int unsigned CNT_W = $clog2(MAX_BR + 1);

    logic              disp_valid;
    logic [TAG_W-1:0]  disp_tag;
    logic              disp_pred_taken;
    logic [ADDR_W-1:0] disp_fallthru_pc;
    logic              disp_ready;
    logic [TAG_W-1:0]  res_tag;
    logic              res_taken;
    logic [ADDR_W-1:0] res_target_pc;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              flush;
    logic [TAG_W-1:0]  flush_tag;
    logic [CNT_W-1:0]  outstanding;

    modport master (
        output disp_valid, disp_tag, disp_pred_taken, disp_fallthru_pc,
        output res_tag, res_taken, res_target_pc,
        input  disp_ready, redirect_valid, redirect_pc, flush, flush_tag, outstanding
    );

    modport slave (
        input  disp_valid, disp_tag, disp_pred_taken, disp_fallthru_pc,
        input  res_tag, res_taken, res_target_pc,
        output disp_ready, redirect_valid, redirect_pc, flush, flush_tag, outstanding
    );
endinterface

// File: rtl/br_age_queue.sv
// Age-ordered circular table of in-flight branches.
//   alloc_en/alloc_entry : write an entry at tail
//   lookup_tag -> hit, hit_idx, hit_pred_taken, hit_fallthru_pc (CAM over valid entries)
//   clear_en/clear_idx   : invalidate one entry
//   kill_en/kill_idx     : invalidate kill_idx and everything younger, tail rewinds to it
//   ptr_full             : tail has lapped head (slot at tail still owned)
//   count                : registered popcount of valid entries
module br_age_queue
    import br_ctrl_pkg::*;
#(
    parameter  int unsigned MAX_BR = 4,
    localparam int unsigned IDX_W  = $clog2(MAX_BR),
    localparam int unsigned CNT_W  = $clog2(MAX_BR + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_en,
    input  br_entry_t            alloc_entry,
    input  logic [BR_TAG_W-1:0]  lookup_tag,
    output logic                 hit,
    output logic [IDX_W-1:0]     hit_idx,
    output logic                 hit_pred_taken,
    output logic [BR_ADDR_W-1:0] hit_fallthru_pc,
    input  logic                 clear_en,
    input  logic [IDX_W-1:0]     clear_idx,
    input  logic                 kill_en,
    input  logic [IDX_W-1:0]     kill_idx,
    output logic                 ptr_full,
    output logic [CNT_W-1:0]     count
);
    br_entry_t         table_q [MAX_BR];
    logic [IDX_W:0]    head_q, tail_q, head_d, tail_d;
    logic [MAX_BR-1:0] valid_d;
    logic [CNT_W-1:0]  count_d;
    logic [IDX_W-1:0]  kill_off, slot_off;
    logic [IDX_W:0]    kill_ptr;

    always_comb begin
        hit             = 1'b0;
        hit_idx         = '0;
        hit_pred_taken  = 1'b0;
        hit_fallthru_pc = '0;
        for (int unsigned i = 0; i < MAX_BR; i++) begin
            if (!hit && table_q[i].valid && table_q[i].tag == lookup_tag) begin
                hit             = 1'b1;
                hit_idx         = IDX_W'(i);
                hit_pred_taken  = table_q[i].pred_taken;
                hit_fallthru_pc = table_q[i].fallthru_pc;
            end
        end
    end

    // Kill range is judged by age offset from head; slots outside the live
    // window are already invalid, so clearing them too is harmless.
    always_comb begin
        kill_off = kill_idx - head_q[IDX_W-1:0];
        kill_ptr = head_q + {1'b0, kill_off};
        slot_off = '0;
        count_d  = '0;
        for (int unsigned i = 0; i < MAX_BR; i++) begin
            valid_d[i] = table_q[i].valid;
            slot_off   = IDX_W'(i) - head_q[IDX_W-1:0];
            if (clear_en && clear_idx == IDX_W'(i))
                valid_d[i] = 1'b0;
            if (kill_en && slot_off >= kill_off)
                valid_d[i] = 1'b0;
            if (alloc_en && tail_q[IDX_W-1:0] == IDX_W'(i))
                valid_d[i] = 1'b1;
            count_d = count_d + CNT_W'(valid_d[i]);
        end
        if (kill_en)
            tail_d = kill_ptr;
        else if (alloc_en)
            tail_d = tail_q + 1'b1;
        else
            tail_d = tail_q;
        // Head retires at most one dead entry per cycle.
        if (head_q != tail_d && !valid_d[head_q[IDX_W-1:0]])
            head_d = head_q + 1'b1;
        else
            head_d = head_q;
    end

    assign ptr_full = (head_q[IDX_W] != tail_q[IDX_W]) &&
                      (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < MAX_BR; i++)
                table_q[i].valid <= 1'b0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            count  <= count_d;
            for (int unsigned i = 0; i < MAX_BR; i++)
                table_q[i].valid <= valid_d[i];
            if (alloc_en)
                table_q[tail_q[IDX_W-1:0]] <= alloc_entry;
        end
    end
endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller: records dispatched branches, checks branch
// unit results against predictions, and on a mispredict redirects fetch,
// flushes younger work and stalls dispatch for FLUSH_CYCLES.
//   clk, rst : clock, synchronous active-high reset
//   bus      : dispatch / result / redirect / flush bundle (slave side)
module branch_resolve_ctrl
    import br_ctrl_pkg::*;
#(
    parameter int unsigned TAG_W        = BR_TAG_W,
    parameter int unsigned ADDR_W       = BR_ADDR_W,
    parameter int unsigned MAX_BR       = 4,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input logic                  clk,
    input logic                  rst,
    branch_resolve_ctrl_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(MAX_BR);
    localparam int unsigned CNT_W = $clog2(MAX_BR + 1);
    localparam int unsigned FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    br_state_e         state_q;
    logic [FC_W-1:0]   flush_cnt_q;
    logic              redirect_valid_q, flush_q;
    logic [ADDR_W-1:0] redirect_pc_q;
    logic [TAG_W-1:0]  flush_tag_q;

    logic                 hit, hit_pred_taken, ptr_full;
    logic [IDX_W-1:0]     hit_idx;
    logic [BR_ADDR_W-1:0] hit_fallthru_pc;
    logic [CNT_W-1:0]     count;
    logic                 res_active, mispredict, correct, disp_ready, alloc_en;
    br_entry_t            alloc_entry;

    // ptr_full additionally guards against overwriting a live head entry
    // when a younger branch was freed out of order.
    always_comb begin
        disp_ready  = (state_q == BR_RUN) && (count < CNT_W'(MAX_BR)) && !ptr_full;
        res_active  = (state_q == BR_RUN) && (bus.res_tag != TAG_INVALID);
        mispredict  = res_active && hit && (bus.res_taken != hit_pred_taken);
        correct     = res_active && hit && (bus.res_taken == hit_pred_taken);
        // A dispatch in a mispredict cycle is younger than the flush point.
        alloc_en    = bus.disp_valid && disp_ready && !mispredict;
        alloc_entry = '{valid: 1'b1, tag: bus.disp_tag,
                        pred_taken: bus.disp_pred_taken,
                        fallthru_pc: bus.disp_fallthru_pc};
    end

    br_age_queue #(.MAX_BR(MAX_BR)) u_queue (
        .clk             (clk),
        .rst             (rst),
        .alloc_en        (alloc_en),
        .alloc_entry     (alloc_entry),
        .lookup_tag      (bus.res_tag),
        .hit             (hit),
        .hit_idx         (hit_idx),
        .hit_pred_taken  (hit_pred_taken),
        .hit_fallthru_pc (hit_fallthru_pc),
        .clear_en        (correct),
        .clear_idx       (hit_idx),
        .kill_en         (mispredict),
        .kill_idx        (hit_idx),
        .ptr_full        (ptr_full),
        .count           (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= BR_RUN;
            flush_cnt_q      <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            flush_q          <= 1'b0;
            flush_tag_q      <= TAG_INVALID;
        end else begin
            redirect_valid_q <= 1'b0;
            case (state_q)
                BR_RUN: begin
                    if (mispredict) begin
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= bus.res_taken ? bus.res_target_pc : hit_fallthru_pc;
                        flush_q          <= 1'b1;
                        flush_tag_q      <= bus.res_tag;
                        flush_cnt_q      <= FC_W'(FLUSH_CYCLES - 1);
                        state_q          <= BR_FLUSH;
                    end
                end
                BR_FLUSH: begin
                    if (flush_cnt_q == '0) begin
                        flush_q     <= 1'b0;
                        flush_tag_q <= TAG_INVALID;
                        state_q     <= BR_RUN;
                    end else begin
                        flush_cnt_q <= flush_cnt_q - 1'b1;
                    end
                end
                default: state_q <= BR_RUN;
            endcase
        end
    end

    assign bus.disp_ready     = disp_ready;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.flush          = flush_q;
    assign bus.flush_tag      = flush_tag_q;
    assign bus.outstanding    = count;
endmodule
